// File: rtl/dram_window_fetch_if.sv
// Frame-memory read port plus the window handshake toward the filter datapath.
interface dram_window_fetch_if #(
    parameter int unsigned D_WIDTH  = 8,
    parameter int unsigned A_WIDTH  = 19,
    parameter int unsigned WIN_BITS = 392
);
    logic                ren;
    logic [A_WIDTH-1:0]  raddr;
    logic [D_WIDTH-1:0]  rdata;
    logic                win_valid;
    logic                win_ready;
    logic [WIN_BITS-1:0] window;

    // Fetch engine side: drives reads and the window word
    modport master (
        output ren, raddr, win_valid, window,
        input  rdata, win_ready
    );

    // Memory/consumer side
    modport slave (
        input  ren, raddr, win_valid, window,
        output rdata, win_ready
    );
endinterface

// File: rtl/dram_window_fetch.sv
// Fetches a WIN x WIN neighbourhood from the frame memory, replicating border
// pixels, and hands it to the filter as one packed window word.
module dram_window_fetch #(
    parameter int unsigned IMG_W   = 640,
    parameter int unsigned IMG_H   = 480,
    parameter int unsigned WIN     = 7,
    parameter int unsigned D_WIDTH = 8,
    parameter int unsigned A_WIDTH = 19
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [9:0] cx,
    input  logic [8:0] cy,
    output logic       busy,
    dram_window_fetch_if.master bus
);
    localparam int unsigned N_ELEM = WIN * WIN;
    localparam int unsigned K_W    = $clog2(N_ELEM + 1);
    localparam int unsigned C_W    = $clog2(WIN);
    localparam int unsigned HALF   = WIN / 2;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

    state_t         state;
    logic [9:0]     cx_q;
    logic [8:0]     cy_q;
    logic [C_W-1:0] col;
    logic [C_W-1:0] row;
    logic [K_W-1:0] issue_k;
    logic [K_W-1:0] cap_k;
    logic           ren_d;

    logic [9:0]         cx_cl_c;
    logic [8:0]         cy_cl_c;
    logic [9:0]         base_x_c;
    logic [8:0]         base_y_c;
    logic [C_W-1:0]     sel_col_c;
    logic [C_W-1:0]     sel_row_c;
    logic signed [10:0] xs_c;
    logic signed [10:0] ys_c;
    logic [9:0]         x_c;
    logic [8:0]         y_c;
    logic [A_WIDTH-1:0] addr_c;

    // Clamp out-of-frame centre coordinates to the last column/row
    assign cx_cl_c = (cx >= 10'(IMG_W)) ? 10'(IMG_W - 1) : cx;
    assign cy_cl_c = (cy >= 9'(IMG_H))  ? 9'(IMG_H - 1)  : cy;

    // Address of the next element; in IDLE it is element 0 of the incoming request
    always_comb begin
        base_x_c  = (state == IDLE) ? cx_cl_c : cx_q;
        base_y_c  = (state == IDLE) ? cy_cl_c : cy_q;
        sel_col_c = (state == IDLE) ? '0 : col;
        sel_row_c = (state == IDLE) ? '0 : row;
        xs_c = $signed({1'b0, base_x_c}) + $signed(11'(sel_col_c)) - $signed(11'(HALF));
        ys_c = $signed({2'b00, base_y_c}) + $signed(11'(sel_row_c)) - $signed(11'(HALF));
        if (xs_c < 0)                              x_c = '0;
        else if (xs_c > $signed(11'(IMG_W - 1)))   x_c = 10'(IMG_W - 1);
        else                                       x_c = xs_c[9:0];
        if (ys_c < 0)                              y_c = '0;
        else if (ys_c > $signed(11'(IMG_H - 1)))   y_c = 9'(IMG_H - 1);
        else                                       y_c = ys_c[8:0];
        addr_c = A_WIDTH'(y_c) * A_WIDTH'(IMG_W) + A_WIDTH'(x_c);
    end

    // Fetch FSM: issue reads back to back, capture returning bytes two edges later, hold until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cx_q          <= '0;
            cy_q          <= '0;
            col           <= '0;
            row           <= '0;
            issue_k       <= '0;
            cap_k         <= '0;
            ren_d         <= 1'b0;
            busy          <= 1'b0;
            bus.ren       <= 1'b0;
            bus.raddr     <= '0;
            bus.win_valid <= 1'b0;
            bus.window    <= '0;
        end else begin
            ren_d <= bus.ren;
            if (ren_d) begin
                bus.window[D_WIDTH * cap_k +: D_WIDTH] <= bus.rdata;
                cap_k <= cap_k + K_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        cx_q       <= cx_cl_c;
                        cy_q       <= cy_cl_c;
                        bus.ren    <= 1'b1;
                        bus.raddr  <= addr_c;
                        busy       <= 1'b1;
                        issue_k    <= K_W'(1);
                        col        <= C_W'(1);
                        row        <= '0;
                        cap_k      <= '0;
                        bus.window <= '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_k == K_W'(N_ELEM)) begin
                        bus.ren <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        bus.raddr <= addr_c;
                        issue_k   <= issue_k + K_W'(1);
                        if (col == C_W'(WIN - 1)) begin
                            col <= '0;
                            row <= row + C_W'(1);
                        end else begin
                            col <= col + C_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    bus.win_valid <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (bus.win_valid && bus.win_ready) begin
                        bus.win_valid <= 1'b0;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_window_fetch.sv
// Bench for dram_window_fetch: memory returns the low address byte.
module tb_dram_window_fetch;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [9:0] cx;
    logic [8:0] cy;
    logic       busy;

    dram_window_fetch_if bus ();

    dram_window_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .cx    (cx),
        .cy    (cy),
        .busy  (busy),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int ren_cnt  = 0;
    int max_addr = 0;
    logic [18:0]  addr_q[$];
    logic [391:0] win_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame memory: mem[a] = a[7:0], one-cycle read latency
    always @(posedge clk) if (bus.ren) bus.rdata <= bus.raddr[7:0];

    task automatic chk(input string tag, input logic [391:0] got, input logic [391:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] mdl_addr(input int x, input int y, input int k);
        int xx, yy;
        if (x > 639) x = 639;
        if (y > 479) y = 479;
        xx = x + (k % 7) - 3;
        yy = y + (k / 7) - 3;
        if (xx < 0) xx = 0;
        if (xx > 639) xx = 639;
        if (yy < 0) yy = 0;
        if (yy > 479) yy = 479;
        return 19'(yy * 640 + xx);
    endfunction

    // Address monitor: every issued read is checked against the expected order
    always @(negedge clk) begin
        if (rst_n && bus.ren) begin
            ren_cnt++;
            if (int'(bus.raddr) > max_addr) max_addr = int'(bus.raddr);
            if (addr_q.size() > 0) chk("raddr", 392'(bus.raddr), 392'(addr_q.pop_front()));
        end
    end

    task automatic push_expect(input int x, input int y, input bit with_win);
        logic [391:0] w;
        logic [18:0]  a;
        w = '0;
        for (int k = 0; k < 49; k++) begin
            a = mdl_addr(x, y, k);
            addr_q.push_back(a);
            w[8*k +: 8] = a[7:0];
        end
        if (with_win) win_q.push_back(w);
    endtask

    task automatic do_fetch(input int x, input int y, input int hold, input bit poke);
        int n;
        logic [391:0] exp_w;
        push_expect(x, y, 1'b1);
        ren_cnt  = 0;
        max_addr = 0;
        bus.win_ready = (hold == 0);
        cx = 10'(x);
        cy = 9'(y);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_rise", 392'(busy), 392'(1));
        n = 0;
        while (!bus.win_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
            start = poke && (n == 10);
        end
        start = 1'b0;
        chk("latency", 392'(n), 392'(50));
        exp_w = (win_q.size() > 0) ? win_q.pop_front() : '0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_window", bus.window, exp_w);
            chk("hold_valid", 392'(bus.win_valid), 392'(1));
            chk("hold_ren", 392'(bus.ren), 392'(0));
            chk("hold_busy", 392'(busy), 392'(1));
        end
        bus.win_ready = 1'b1;
        start = poke;
        chk("window", bus.window, exp_w);
        @(posedge clk); #1;
        start = 1'b0;
        chk("hs_valid_low", 392'(bus.win_valid), 392'(0));
        chk("hs_busy_low", 392'(busy), 392'(0));
        repeat (3) begin @(posedge clk); #1; end
        bus.win_ready = 1'b0;
        chk("idle_busy", 392'(busy), 392'(0));
        chk("idle_valid", 392'(bus.win_valid), 392'(0));
        chk("ren_count", 392'(ren_cnt), 392'(49));
        chk("addr_q_left", 392'(addr_q.size()), 392'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cx = '0;
        cy = '0;
        bus.win_ready = 1'b0;
        #2;
        chk("rst_busy", 392'(busy), 392'(0));
        chk("rst_ren", 392'(bus.ren), 392'(0));
        chk("rst_raddr", 392'(bus.raddr), 392'(0));
        chk("rst_valid", 392'(bus.win_valid), 392'(0));
        chk("rst_window", bus.window, 392'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Centre of frame, consumer already ready
        do_fetch(320, 240, 0, 1'b0);
        // Top-left corner
        do_fetch(0, 0, 0, 1'b0);
        chk("corner0_max", 392'(max_addr), 392'(1923));
        // Bottom-right corner
        do_fetch(639, 479, 0, 1'b0);
        chk("corner1_max", 392'(max_addr), 392'(307199));
        // Out-of-range centre clamps to the last pixel
        do_fetch(1000, 500, 0, 1'b0);
        // Consumer back-pressure for 10 cycles
        do_fetch(50, 7, 10, 1'b0);
        // Stray start pulses mid-fetch and in the completing HOLD cycle
        do_fetch(200, 300, 2, 1'b1);

        // Reset in the middle of a fetch
        push_expect(320, 240, 1'b0);
        ren_cnt = 0;
        cx = 10'(320);
        cy = 9'(240);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_ren", 392'(bus.ren), 392'(0));
        chk("midrst_busy", 392'(busy), 392'(0));
        chk("midrst_valid", 392'(bus.win_valid), 392'(0));
        chk("midrst_window", bus.window, 392'(0));
        addr_q.delete();
        win_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_fetch(100, 100, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
